fetch_decode_queue: RTL and testbench

//  Parametrised fetch->decode pipeline buffer. Successor to the single-entry F/D register.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fetch_decode_queue.sv | 122 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch/decode entry layout and the canonical NOP.
package pipeline_pkg;

    localparam int FD_ADDR_W = 32;
    localparam int FD_DATA_W = 32;

    // addi x0, x0, 0
    localparam logic [FD_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FD_DATA_W-1:0] instr;
        logic [FD_ADDR_W-1:0] pc;
        logic [FD_ADDR_W-1:0] pc_plus4;
    } fd_entry_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Fetch->decode buffer: DEPTH-entry circular FIFO of {instr, pc, pc+4} with
// valid/ready on both sides and a flush for branch/jump redirects.
// Optional feature macro: FDQ_BYPASS_EN (zero-latency fall-through when empty).
module fetch_decode_queue
    import pipeline_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FD_ADDR_W,
    parameter int DATA_WIDTH    = FD_DATA_W,
    parameter int DEPTH         = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_WIDTH-1:0]      rd_i,
    input  logic [ADDRESS_WIDTH-1:0]   pcF_i,
    input  logic [ADDRESS_WIDTH-1:0]   pc_plus4F_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH-1:0]      instrD_o,
    output logic [ADDRESS_WIDTH-1:0]   pcD_o,
    output logic [ADDRESS_WIDTH-1:0]   pc_plus4D_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointer wrap relies on natural modulo-2^PTR_W overflow.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("fetch_decode_queue: DEPTH must be a power of two and >= 2");
    end

    fd_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               stored_s;
    logic               bypass_s;
    logic               push_s;
    logic               pop_s;
    fd_entry_t          in_entry_s;
    fd_entry_t          head_s;

    assign stored_s   = (count_r != {CNT_W{1'b0}});
    assign in_ready_o = (count_r != CNT_W'(DEPTH));
    assign count_o    = count_r;

`ifdef FDQ_BYPASS_EN
    assign bypass_s = ~stored_s & in_valid_i & ~flush_i;
`else
    assign bypass_s = 1'b0;
`endif

    assign out_valid_o = stored_s | bypass_s;

    // A bypassed entry taken by decode in the same cycle is never stored.
    assign push_s = in_valid_i & in_ready_o & ~(bypass_s & out_ready_i);
    assign pop_s  = stored_s & out_ready_i;

    assign in_entry_s = '{instr: rd_i, pc: pcF_i, pc_plus4: pc_plus4F_i};
    assign head_s     = mem_r[rd_ptr_r];

    // Head presentation: bypassed input, stored head, or NOP/0/0 when empty.
    always_comb begin
        instrD_o    = NOP_INSTR;
        pcD_o       = {ADDRESS_WIDTH{1'b0}};
        pc_plus4D_o = {ADDRESS_WIDTH{1'b0}};
        if (bypass_s) begin
            instrD_o    = in_entry_s.instr;
            pcD_o       = in_entry_s.pc;
            pc_plus4D_o = in_entry_s.pc_plus4;
        end else if (stored_s) begin
            instrD_o    = head_s.instr;
            pcD_o       = head_s.pc;
            pc_plus4D_o = head_s.pc_plus4;
        end else begin
            instrD_o    = NOP_INSTR;
            pcD_o       = {ADDRESS_WIDTH{1'b0}};
            pc_plus4D_o = {ADDRESS_WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy control: reset > flush > push/pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are don't-care until counted as occupied.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && push_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed, table-driven bench for fetch_decode_queue (DEPTH=4).
module tb_fetch_decode_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rd;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [2:0]  count;

    int pass_cnt;
    int total_cnt;

    fetch_decode_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .rd_i        (rd),
        .pcF_i       (pc_f),
        .pc_plus4F_i (pc4_f),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .instrD_o    (instr_d),
        .pcD_o       (pc_d),
        .pc_plus4D_o (pc4_d),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [31:0] pc;
        logic [2:0]  exp_count;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_pc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] pc, input logic [2:0] c, input logic ov,
                       input logic ir, input logic [31:0] hpc, input string name);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.pc = pc;
        v.exp_count = c; v.exp_ov = ov; v.exp_ir = ir; v.exp_pc = hpc; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [31:0] pc);
        rst_n = r; flush = f; in_valid = iv; out_ready = ordy;
        pc_f = pc; pc4_f = pc + 32'd4; rd = instr_of(pc);
    endtask

    task automatic check_state(input string name, input logic [2:0] c, input logic ov,
                               input logic ir, input logic [31:0] hpc);
        check({name, ".count"}, {29'd0, count}, {29'd0, c});
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        if (ov) begin
            check({name, ".pcD"}, pc_d, hpc);
            check({name, ".instrD"}, instr_d, instr_of(hpc));
            check({name, ".pc4D"}, pc4_d, hpc + 32'd4);
        end else begin
            check({name, ".pcD"}, pc_d, 32'd0);
            check({name, ".instrD"}, instr_d, NOP);
            check({name, ".pc4D"}, pc4_d, 32'd0);
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Reset held two cycles with fetch presenting.
        add(0,0,1,0, 32'h200, 3'd0,0,1, 32'h0, "rst0");
        add(0,0,1,0, 32'h204, 3'd0,0,1, 32'h0, "rst1");
        // Fill four, fifth rejected.
        add(1,0,1,0, 32'h0,   3'd1,1,1, 32'h0, "fill0");
        add(1,0,1,0, 32'h4,   3'd2,1,1, 32'h0, "fill1");
        add(1,0,1,0, 32'h8,   3'd3,1,1, 32'h0, "fill2");
        add(1,0,1,0, 32'hC,   3'd4,1,0, 32'h0, "fill3");
        add(1,0,1,0, 32'h10,  3'd4,1,0, 32'h0, "fill_over");
        // Drain in order; 0x10 must not appear.
        add(1,0,0,1, 32'h0,   3'd3,1,1, 32'h4, "drain0");
        add(1,0,0,1, 32'h0,   3'd2,1,1, 32'h8, "drain1");
        add(1,0,0,1, 32'h0,   3'd1,1,1, 32'hC, "drain2");
        add(1,0,0,1, 32'h0,   3'd0,0,1, 32'h0, "drain3");
        // Simultaneous push/pop at count 2, pointers wrap.
        add(1,0,1,0, 32'h20,  3'd1,1,1, 32'h20, "sim_pre0");
        add(1,0,1,0, 32'h24,  3'd2,1,1, 32'h20, "sim_pre1");
        for (int k = 1; k <= 10; k++) begin
            add(1,0,1,1, 32'h24 + 32'(4*k), 3'd2,1,1, 32'h20 + 32'(4*k), $sformatf("sim%0d", k));
        end
        // Flush at count 3 with a concurrent push.
        add(1,0,1,0, 32'h50,  3'd3,1,1, 32'h48, "flush_pre");
        add(1,1,1,0, 32'h40,  3'd0,0,1, 32'h0, "flush");
        add(1,0,0,0, 32'h0,   3'd0,0,1, 32'h0, "flush_idle");
        // Empty latency then full+pop.
        add(1,0,1,0, 32'h100, 3'd1,1,1, 32'h100, "empty_push");
        add(1,0,1,0, 32'h104, 3'd2,1,1, 32'h100, "fp0");
        add(1,0,1,0, 32'h108, 3'd3,1,1, 32'h100, "fp1");
        add(1,0,1,0, 32'h10C, 3'd4,1,0, 32'h100, "fp2");
        add(1,0,1,1, 32'h110, 3'd3,1,1, 32'h104, "full_pop");
        add(1,0,0,1, 32'h0,   3'd2,1,1, 32'h108, "fp_drain0");
        add(1,0,0,1, 32'h0,   3'd1,1,1, 32'h10C, "fp_drain1");
        add(1,0,0,1, 32'h0,   3'd0,0,1, 32'h0, "fp_drain2");
        // Reset mid-traffic discards entries.
        add(1,0,1,0, 32'h200, 3'd1,1,1, 32'h200, "mid_push");
        add(1,0,1,0, 32'h204, 3'd2,1,1, 32'h200, "mid_push2");
        add(0,0,1,1, 32'h208, 3'd0,0,1, 32'h0, "mid_rst");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].pc);
            @(posedge clk);
            #1;
            check_state(vecs[i].name, vecs[i].exp_count, vecs[i].exp_ov,
                        vecs[i].exp_ir, vecs[i].exp_pc);
        end

        // Same-cycle visibility of a push into an empty queue.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300);
        #1;
`ifdef FDQ_BYPASS_EN
        check("lat_pre.out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_pre.pcD", pc_d, 32'h300);
`else
        check("lat_pre.out_valid", {31'd0, out_valid}, 32'd0);
        check("lat_pre.instrD", instr_d, NOP);
`endif
        @(posedge clk);
        #1;
        check_state("lat_post", 3'd1, 1'b1, 1'b1, 32'h300);

        // Drain, then push with decode ready: one entry passes through.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check_state("lat_drain", 3'd0, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h304);
        @(posedge clk);
        #1;
`ifdef FDQ_BYPASS_EN
        check_state("bypass_take", 3'd0, 1'b1, 1'b1, 32'h304);
`else
        check_state("bypass_take", 3'd1, 1'b1, 1'b1, 32'h304);
`endif

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
